// File: rtl/fp16_conv_arbiter.sv
// Round-robin front end that time-shares one int_to_fp16 converter between NUM_REQ producers.
// Optional watchdog on the converter's done pulse: define CONV_TIMEOUT_EN.
module fp16_conv_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [20*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    conv_valid,
    output logic [19:0]             conv_data,
    input  logic                    conv_done,
    input  logic [15:0]             conv_result,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [15:0]             rsp_data,
    input  logic                    rsp_ready,
    output logic                    busy
`ifdef CONV_TIMEOUT_EN
    ,
    output logic                    rsp_err,
    output logic                    timeout_err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [19:0]       conv_data_reg, conv_data_next;
    logic [ID_W-1:0]   rsp_id_reg, rsp_id_next;
    logic [15:0]       rsp_data_reg, rsp_data_next;

    logic [19:0]        req_word [NUM_REQ];
    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] masked_valid;
    logic [NUM_REQ-1:0] pick_src;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [ID_W-1:0]    pick_idx;
    logic               transfer;
    logic               timed_out;

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("fp16_conv_arbiter: NUM_REQ must be 2..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fp16_conv_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    // Requesters above the last winner get first pick; otherwise wrap to the lowest index.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign req_word[gi]   = req_data[20*gi +: 20];
            assign upper_mask[gi] = (ID_W'(gi) > rr_ptr_reg);
        end
    endgenerate

    assign masked_valid = req_valid & upper_mask;
    assign pick_src     = (|masked_valid) ? masked_valid : req_valid;
    assign pick_onehot  = pick_src & (~pick_src + NUM_REQ'(1));

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
                pick_idx = ID_W'(i);
            end
        end
    end

    assign req_ready = (state_reg == IDLE) ? pick_onehot : '0;
    assign transfer  = |(req_valid & req_ready);

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        conv_data_next = conv_data_reg;
        rsp_id_next    = rsp_id_reg;
        rsp_data_next  = rsp_data_reg;
        case (state_reg)
            IDLE: begin
                if (transfer) begin
                    conv_data_next = req_word[pick_idx];
                    rsp_id_next    = pick_idx;
                    rr_ptr_next    = pick_idx;
                    state_next     = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (conv_done) begin
                    rsp_data_next = conv_result;
                    state_next    = RESP;
                end else if (timed_out) begin
                    rsp_data_next = 16'h7E00;
                    state_next    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= ID_W'(NUM_REQ - 1);
            conv_data_reg <= '0;
            rsp_id_reg    <= '0;
            rsp_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            conv_data_reg <= conv_data_next;
            rsp_id_reg    <= rsp_id_next;
            rsp_data_reg  <= rsp_data_next;
        end
    end

`ifdef CONV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             rsp_err_reg, rsp_err_next;
    logic             timeout_err_reg, timeout_err_next;

    // A done arriving on the final watchdog cycle still counts as a normal completion.
    assign timed_out = (state_reg == WAIT) && !conv_done &&
                       (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_cnt_next    = '0;
        rsp_err_next     = rsp_err_reg;
        timeout_err_next = timeout_err_reg | timed_out;
        if (state_reg == WAIT) begin
            wait_cnt_next = wait_cnt_reg + CNT_W'(1);
            if (conv_done) begin
                rsp_err_next = 1'b0;
            end else if (timed_out) begin
                rsp_err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg    <= '0;
            rsp_err_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            wait_cnt_reg    <= wait_cnt_next;
            rsp_err_reg     <= rsp_err_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    assign rsp_err     = rsp_err_reg;
    assign timeout_err = timeout_err_reg;
`else
    assign timed_out = 1'b0;
`endif

    assign conv_valid = (state_reg == ISSUE);
    assign conv_data  = conv_data_reg;
    assign rsp_valid  = (state_reg == RESP);
    assign rsp_id     = rsp_id_reg;
    assign rsp_data   = rsp_data_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_fp16_conv_arbiter.sv
// Bench for fp16_conv_arbiter: converter stand-in, transaction-level reference model and directed vectors.
// Build with CONV_TIMEOUT_EN defined to also exercise the watchdog.
module tb_fp16_conv_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TO  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [20*N-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              conv_valid;
    logic [19:0]       conv_data;
    logic              conv_done;
    logic [15:0]       conv_result;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_data;
    logic              rsp_ready;
    logic              busy;
`ifdef CONV_TIMEOUT_EN
    logic              rsp_err;
    logic              timeout_err;
`endif

    always #5 clk = ~clk;

    fp16_conv_arbiter #(.NUM_REQ(N), .ID_W(IDW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .conv_valid(conv_valid), .conv_data(conv_data),
        .conv_done(conv_done), .conv_result(conv_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .busy(busy)
`ifdef CONV_TIMEOUT_EN
        , .rsp_err(rsp_err), .timeout_err(timeout_err)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Integer to FP16, round to nearest even, overflow to infinity.
    function automatic logic [15:0] fp16_ref(input logic [19:0] v);
        logic s;
        int mag, p, sh, m, rem, half, e;
        s   = v[19];
        mag = s ? (1048576 - int'({12'b0, v})) : int'({12'b0, v});
        if (mag == 0) return 16'h0000;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        if (p <= 10) begin
            m = mag << (10 - p);
        end else begin
            sh   = p - 10;
            m    = mag >> sh;
            rem  = mag & ((1 << sh) - 1);
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (m & 1) == 1)) m++;
            if (m == 2048) begin
                m = 1024;
                p++;
            end
        end
        e = p + 15;
        if (e >= 31) return {s, 15'h7C00};
        return {s, 5'(e), 10'(m & 1023)};
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Converter stand-in: result ready eight cycles after valid, data taken one cycle after valid.
    int          cd_cnt;
    logic [15:0] cv_out;
    logic        stuck;
    logic        spurious;

    always @(posedge clk) begin
        if (rst) begin
            cd_cnt <= 0;
            cv_out <= '0;
        end else begin
            if (conv_valid) cd_cnt <= 8;
            else if (cd_cnt > 0) cd_cnt <= cd_cnt - 1;
            if (cd_cnt == 8) cv_out <= fp16_ref(conv_data);
        end
    end
    assign conv_done   = ((cd_cnt == 1) && !stuck) || spurious;
    assign conv_result = cv_out;

    // Reference model: tracks the age of the current job in cycles since it was accepted.
    bit             m_idle;
    int             m_age;
    int             m_ptr;
    int             m_ra;
    logic [IDW-1:0] m_id;
    logic [19:0]    m_data;
    logic [15:0]    m_rsp;
    bit             m_err;
    bit             m_terr;
    bit             chk_en;

    always @(posedge clk) begin : model_upd
        int g;
        if (rst) begin
            m_idle <= 1'b1; m_age <= 0; m_ptr <= N - 1; m_ra <= 10;
            m_id <= '0; m_data <= '0; m_rsp <= '0; m_err <= 1'b0; m_terr <= 1'b0;
        end else if (m_idle) begin
            g = pick(req_valid, m_ptr);
            if (g >= 0) begin
                m_idle <= 1'b0;
                m_age  <= 1;
                m_ptr  <= g;
                m_id   <= IDW'(g);
                m_data <= req_data[20*g +: 20];
                m_ra   <= stuck ? (2 + TO) : 10;
            end
        end else if (m_age >= m_ra) begin
            if (rsp_ready) m_idle <= 1'b1;
        end else begin
            if (m_age == m_ra - 1) begin
                m_rsp <= stuck ? 16'h7E00 : fp16_ref(m_data);
                m_err <= stuck;
                if (stuck) m_terr <= 1'b1;
            end
            m_age <= m_age + 1;
        end
    end

    always @(negedge clk) begin : compare
        int g;
        logic [N-1:0] er;
        if (chk_en) begin
            g  = pick(req_valid, m_ptr);
            er = (m_idle && g >= 0) ? N'(1 << g) : '0;
            check("req_ready",  32'(req_ready),  32'(er));
            check("busy",       32'(busy),       32'(!m_idle));
            check("conv_valid", 32'(conv_valid), 32'(!m_idle && m_age == 1));
            check("conv_data",  32'(conv_data),  32'(m_data));
            check("rsp_valid",  32'(rsp_valid),  32'(!m_idle && m_age >= m_ra));
            check("rsp_id",     32'(rsp_id),     32'(m_id));
            check("rsp_data",   32'(rsp_data),   32'(m_rsp));
`ifdef CONV_TIMEOUT_EN
            check("rsp_err",     32'(rsp_err),     32'(m_err));
            check("timeout_err", 32'(timeout_err), 32'(m_terr));
`endif
            if (rsp_valid && rsp_ready)
                $display("rsp id=%0d data=%h t=%0t", rsp_id, rsp_data, $time);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_single(input int idx, input logic [19:0] d, input logic [15:0] exp);
        req_data = '0;
        req_data[20*idx +: 20] = d;
        req_valid = '0;
        req_valid[idx] = 1'b1;
        @(negedge clk);
        check("grant_onehot", 32'(req_ready), 32'(1 << idx));
        tick;
        req_valid = '0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("lat_rsp_valid", 32'(rsp_valid), 32'd1);
        check("lat_rsp_id",    32'(rsp_id),    32'(idx));
        check("lat_rsp_data",  32'(rsp_data),  32'(exp));
        tick;
    endtask

    int acc_id [8];
    int acc_cyc[8];
    int n_acc;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
        stuck = 1'b0; spurious = 1'b0; chk_en = 1'b0;

        check("ref_5",     32'(fp16_ref(20'd5)),     32'h4500);
        check("ref_m1",    32'(fp16_ref(20'hFFFFF)), 32'hBC00);
        check("ref_0",     32'(fp16_ref(20'd0)),     32'h0000);
        check("ref_65520", 32'(fp16_ref(20'd65520)), 32'h7C00);
        check("ref_65519", 32'(fp16_ref(20'd65519)), 32'h7BFF);
        check("ref_2049",  32'(fp16_ref(20'd2049)),  32'h6800);
        check("ref_min",   32'(fp16_ref(20'h80000)), 32'hFC00);

        tick;
        chk_en = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_conv_data", 32'(conv_data), 32'd0);
        tick;

        do_single(1, 20'd5,     16'h4500);
        do_single(0, 20'hFFFFF, 16'hBC00);
        do_single(0, 20'd0,     16'h0000);
        do_single(0, 20'd65520, 16'h7C00);
        do_single(3, 20'h80000, 16'hFC00);
        do_single(1, 20'd2049,  16'h6800);

        // stray done while idle must be ignored
        spurious = 1'b1;
        tick;
        spurious = 1'b0;
        repeat (3) tick;

        // all requesters busy: round-robin order and 11-cycle spacing
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < N; i++) req_data[20*i +: 20] = 20'(i + 1);
        req_valid = '1;
        n_acc = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (|(req_valid & req_ready) && n_acc < 8) begin
                for (int i = 0; i < N; i++)
                    if (req_ready[i]) acc_id[n_acc] = i;
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            tick;
        end
        req_valid = '0;
        check("rr_count", 32'(n_acc), 32'd5);
        for (int k = 0; k < 5 && k < n_acc; k++) begin
            check("rr_order", 32'(acc_id[k]), 32'(k % N));
            if (k > 0) check("rr_gap", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd11);
        end
        repeat (12) tick;

        // consumer stalls in RESP
        rsp_ready = 1'b0;
        req_data[40 +: 20] = 20'd7;
        req_valid = 4'b0100;
        @(negedge clk);
        check("stall_grant", 32'(req_ready), 32'h4);
        tick;
        req_valid = '1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick;
            @(negedge clk);
            check("stall_hold_valid", 32'(rsp_valid), 32'd1);
            check("stall_hold_id",    32'(rsp_id),    32'd2);
            check("stall_hold_data",  32'(rsp_data),  32'h4700);
            check("stall_no_ready",   32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick;
        @(negedge clk);
        check("stall_next_grant", 32'(req_ready), 32'h8);
        req_valid = '0;
        tick;

        // reset while waiting on the converter
        req_data = '0;
        req_data[20 +: 20] = 20'd9;
        req_valid = 4'b0010;
        tick;
        req_valid = '0;
        repeat (2) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        check("wrst_busy",      32'(busy),      32'd0);
        check("wrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("wrst_conv_data", 32'(conv_data), 32'd0);
        repeat (12) tick;
        do_single(2, 20'd3, 16'h4200);

`ifdef CONV_TIMEOUT_EN
        // converter never answers
        stuck = 1'b1;
        req_data = '0;
        req_data[20 +: 20] = 20'd5;
        req_valid = 4'b0010;
        tick;
        req_valid = '0;
        repeat (32) @(posedge clk);
        @(negedge clk);
        check("to_not_yet", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("to_rsp_valid",   32'(rsp_valid),   32'd1);
        check("to_rsp_data",    32'(rsp_data),    32'h7E00);
        check("to_rsp_err",     32'(rsp_err),     32'd1);
        check("to_timeout_err", 32'(timeout_err), 32'd1);
        tick;
        stuck = 1'b0;
        do_single(0, 20'd5, 16'h4500);
        @(negedge clk);
        check("to_err_clear",  32'(rsp_err),     32'd0);
        check("to_err_sticky", 32'(timeout_err), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        check("to_err_reset", 32'(timeout_err), 32'd0);
        tick;
`endif

        repeat (2) tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fp16_conv_arbiter.md
Name: fp16_conv_arbiter

Overview:
- Round-robin scheduler that shares one int_to_fp16 converter among NUM_REQ requesters.
- Accepts one 20-bit signed integer per grant and drives the converter's valid/data inputs.
- Waits for the converter's done pulse, then returns the FP16 result tagged with the requester ID.
- Sits between the integer producers (accumulator/PE outputs) and the single shared converter instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), width of the requester ID field.
- TIMEOUT_CYCLES, 32, watchdog limit in WAIT. Used only with CONV_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_data  in  20*NUM_REQ  packed signed integers; requester i occupies [20*i+19:20*i].
- req_ready  out  NUM_REQ  one-hot accept; a transfer happens when req_valid[i] && req_ready[i].
- conv_valid  out  1  to converter valid_in.
- conv_data  out  20  to converter integer_in.
- conv_done  in  1  from converter done_out.
- conv_result  in  16  from converter fp16_out.
- rsp_valid  out  1  result available.
- rsp_id  out  ID_W  requester that owns the result.
- rsp_data  out  16  FP16 result.
- rsp_ready  in  1  consumer accepts the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE, rr_ptr=NUM_REQ-1, req_ready=0, conv_valid=0, conv_data=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
- Integration: the converter's rst_n must be tied to ~rst so that both blocks reset together.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is combinational. It is one-hot on the first asserted req_valid, searching from (rr_ptr+1) mod NUM_REQ upward with wrap.
  - On a transfer: latch req_data slice into conv_data and the index into rsp_id, set rr_ptr=index, go to ISSUE.
  - req_ready is 0 in all states other than IDLE.
- ISSUE: conv_valid=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - conv_data is held stable, because the converter samples it one cycle after valid.
  - When conv_done=1, register conv_result into rsp_data and go to RESP.
- RESP:
  - rsp_valid=1; rsp_id and rsp_data are held stable until rsp_ready=1.
  - When rsp_ready=1, go to IDLE; rsp_valid drops the next cycle.
- Latency: request accepted at cycle T gives conv_valid at T+1, conv_done at T+9, and rsp_valid at T+10.
- Throughput: with rsp_ready held high, the minimum spacing between accepts is 11 cycles.
- conv_done seen outside WAIT is ignored.
- rr_ptr changes only on a transfer. Requests that are not granted need not be held; the arbiter keeps no per-requester state.
- A requester that drops req_valid before being granted loses nothing; there is no queueing.
- rst asserted in any state returns the block to IDLE on the next edge with all reset values; any in-flight result is discarded.
- Simultaneous rsp_ready and new req_valid in RESP: the new request is not accepted until the IDLE cycle that follows.

Optional Feature:
- Macro: CONV_TIMEOUT_EN.
- When defined:
  - Adds outputs rsp_err (1 bit) and timeout_err (1 bit, sticky).
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If the count reaches TIMEOUT_CYCLES without conv_done, go to RESP with rsp_data=16'h7E00 (qNaN) and rsp_err=1, and set timeout_err. timeout_err clears only on rst.
  - rsp_err=0 on normal completion.
- When undefined: no counter and no extra ports; WAIT lasts until conv_done.

Test Plan:
- Single request from req 1 with data 20'd5 and rsp_ready=1 -> req_ready[1] at T; rsp_valid at T+10 with rsp_id=1, rsp_data=16'h4500.
- req 0 with data 20'hFFFFF (-1) -> rsp_data=16'hBC00. Data 20'd0 -> 16'h0000. Data 20'd65520 -> 16'h7C00 (round-up overflow to inf).
- All four req_valid held high with rsp_ready=1 -> grant order 0,1,2,3,0; accepts spaced 11 cycles apart.
- rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_data stay stable; req_ready stays 0; the next grant comes only after the handshake.
- rst pulsed during WAIT, then a new request from req 2 with data 20'd3 -> clean restart with rsp_id=2, rsp_data=16'h4200, and no stale response.
- CONV_TIMEOUT_EN with conv_done tied 0 and TIMEOUT_CYCLES=32 -> rsp_valid 32 cycles after entering WAIT, with rsp_data=16'h7E00, rsp_err=1 and timeout_err=1 until rst.
